// File: rtl/bin2bcd_seq_pkg.sv
// Shared display types: BCD digit width, digit type and converter states.
// Imported by the binary-to-BCD converter and by the hex7seg drivers.
package display_pkg;

   localparam int BCD_W = 4;

   typedef enum logic {IDLE, SHIFT} b2b_state_t;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the converter and its client.
// The client (master) drives start/bin; the converter (slave) drives the rest.
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 12,
   parameter int DIGITS = 4
);

   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;

   modport master (
      output start, bin,
      input  busy, done, bcd, ovf
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, ovf
   );

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// Add-3 adjust for one BCD digit ahead of the left shift.
// Inputs are 0..9, so the 4-bit result never exceeds 4'hC.
module bcd_digit_adj
   import display_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t d_adj
);

   assign d_adj = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Result registers only change on done, so the display never sees partials.
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int DIGITS = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   bin2bcd_seq_if.slave  bus
);

   localparam int BW    = BCD_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
   localparam logic [BW-1:0]    NINES = {DIGITS{4'h9}};

   b2b_state_t         r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [BW-1:0]      r_work;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf_st;
   logic               r_busy;
   logic               r_done;
   logic               r_ovf;
   logic [BW-1:0]      r_bcd;

   logic [BW-1:0]      w_adj;
   logic [BW-1:0]      w_work_nxt;
   logic               w_ovf_nxt;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .d     (r_work[g*BCD_W +: BCD_W]),
            .d_adj (w_adj[g*BCD_W +: BCD_W])
         );
      end
   endgenerate

   // A 1 leaving the top digit means the value no longer fits
   assign w_work_nxt = {w_adj[BW-2:0], r_shreg[WIDTH-1]};
   assign w_ovf_nxt  = r_ovf_st | w_adj[BW-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_shreg  <= '0;
         r_work   <= '0;
         r_cnt    <= '0;
         r_ovf_st <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_bcd    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_shreg  <= bus.bin;
                  r_work   <= '0;
                  r_ovf_st <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
               r_work   <= w_work_nxt;
               r_ovf_st <= w_ovf_nxt;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_bcd   <= w_ovf_nxt ? NINES : w_work_nxt;
                  r_ovf   <= w_ovf_nxt;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.bcd  = r_bcd;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: 4-digit and 3-digit converters fed the same stimulus,
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

   localparam int W = 12;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [W-1:0]  bin;

   bin2bcd_seq_if #(.WIDTH(W), .DIGITS(4)) u4 ();
   bin2bcd_seq_if #(.WIDTH(W), .DIGITS(3)) u3 ();

   assign u4.start = start;
   assign u4.bin   = bin;
   assign u3.start = start;
   assign u3.bin   = bin;

   bin2bcd_seq #(.WIDTH(W), .DIGITS(4)) u_dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u4.slave)
   );

   bin2bcd_seq #(.WIDTH(W), .DIGITS(3)) u_dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u3.slave)
   );

   typedef struct {
      int          cyc;
      logic [15:0] b4;
      logic        o4;
      logic [15:0] b3;
      logic        o3;
   } exp_t;

   exp_t         q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc   = 0;
   int           cnt   = 0;
   logic [15:0]  cur4  = '0;
   logic [15:0]  cur3  = '0;
   logic         co4   = 1'b0;
   logic         co3   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_bcd(int v, int d, output logic o);
      logic [15:0] r;
      int lim;
      int x;
      r   = '0;
      lim = 1;
      x   = v;
      for (int i = 0; i < d; i++) lim *= 10;
      o = (v >= lim);
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = o ? 4'd9 : 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic s, logic [W-1:0] b, int n);
      start = s;
      bin   = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: acceptance timing plus expected results
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            q.delete();
            cnt  = 0;
            cur4 = '0;
            cur3 = '0;
            co4  = 1'b0;
            co3  = 1'b0;
         end else begin
            cyc++;
            if (cnt == 0 && start) begin
               e.cyc = cyc + W;
               e.b4  = ref_bcd(int'(bin), 4, e.o4);
               e.b3  = ref_bcd(int'(bin), 3, e.o3);
               q.push_back(e);
               cnt = W;
            end else if (cnt > 0) begin
               cnt--;
            end
         end
      end
   end

   // Monitor
   initial begin
      exp_t e;
      wait (reset_n === 1'b1);
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("done_missing", 32'd0, 32'd1);
            e = q.pop_front();
         end
         if (u4.done || u3.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("done4", 32'(u4.done), 32'd1);
               chk("done3", 32'(u3.done), 32'd1);
               chk("latency", 32'(cyc), 32'(e.cyc));
               chk("bcd4", 32'(u4.bcd), 32'(e.b4));
               chk("ovf4", 32'(u4.ovf), 32'(e.o4));
               chk("bcd3", 32'(u3.bcd), 32'(e.b3));
               chk("ovf3", 32'(u3.ovf), 32'(e.o3));
               cur4 = e.b4;
               cur3 = e.b3;
               co4  = e.o4;
               co3  = e.o3;
            end
         end
         chk("busy4", 32'(u4.busy), 32'(cnt != 0));
         chk("busy3", 32'(u3.busy), 32'(cnt != 0));
         chk("hold_bcd4", 32'(u4.bcd), 32'(cur4));
         chk("hold_bcd3", 32'(u3.bcd), 32'(cur3));
         chk("hold_ovf4", 32'(u4.ovf), 32'(co4));
         chk("hold_ovf3", 32'(u3.ovf), 32'(co3));
      end
   end

   initial begin
      int vals[6] = '{0, 4095, 999, 10, 1000, 7};
      reset_n = 1'b0;
      start   = 1'b0;
      bin     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(u4.busy), 32'd0);
      chk("rst_done", 32'(u4.done), 32'd0);
      chk("rst_bcd4", 32'(u4.bcd), 32'd0);
      chk("rst_ovf4", 32'(u4.ovf), 32'd0);
      chk("rst_bcd3", 32'(u3.bcd), 32'd0);
      chk("rst_ovf3", 32'(u3.ovf), 32'd0);
      reset_n = 1'b1;
      drive(1'b0, '0, 2);

      foreach (vals[i]) begin
         drive(1'b1, W'(vals[i]), 1);
         drive(1'b0, '0, 13);
      end

      // Second start five cycles in must be ignored
      drive(1'b1, 12'd321, 1);
      drive(1'b0, '0, 4);
      drive(1'b1, 12'd555, 1);
      drive(1'b0, '0, 10);

      drive(1'b1, 12'd123, 40);
      drive(1'b0, '0, 14);

      // Abort mid-conversion
      drive(1'b1, 12'd2345, 1);
      drive(1'b0, '0, 5);
      chk("pre_rst_busy", 32'(u4.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy4", 32'(u4.busy), 32'd0);
      chk("abort_bcd4", 32'(u4.bcd), 32'd0);
      chk("abort_ovf4", 32'(u4.ovf), 32'd0);
      chk("abort_busy3", 32'(u3.busy), 32'd0);
      chk("abort_bcd3", 32'(u3.bcd), 32'd0);
      chk("abort_ovf3", 32'(u3.ovf), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(1'b0, '0, 15);
      drive(1'b1, 12'd2345, 1);
      drive(1'b0, '0, 13);

      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 4095)),
               int'($urandom_range(1, 16)));
      end
      drive(1'b0, '0, 14);

      for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
      chk("drain", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
